axi_burst_addr_gen: RTL
=======================

Name: axi_burst_addr_gen

Overview:
Per-beat address generator for one AXI address channel (AW or AR) inside the crossbar slave port. It accepts one burst command (addr, len, size, burst) through a valid/ready handshake and emits len+1 beat descriptors through a second valid/ready handshake. Each descriptor carries the beat address, beat index, last flag and an error flag, and feeds the W/R data-path steering logic downstream. Burst size, burst type and legality rules are those of the AXI4 spec (FIXED=2'b00, INCR=2'b01, WRAP=2'b10, 2'b11 reserved).

Parameters:
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 64, data bus width in bits; power of two, 8..1024; max legal size = log2(DATA_WIDTH/8).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
cmd_valid_i  in  1  burst command valid.
cmd_ready_o  out  1  command accepted when valid&&ready.
cmd_addr_i  in  ADDR_WIDTH  start address.
cmd_len_i  in  8  beats minus one.
cmd_size_i  in  3  log2(bytes per beat).
cmd_burst_i  in  2  burst type.
beat_valid_o  out  1  beat descriptor valid.
beat_ready_i  in  1  downstream accepts beat.
beat_addr_o  out  ADDR_WIDTH  address of current beat.
beat_idx_o  out  8  beat number, 0..len.
beat_last_o  out  1  final beat of burst.
beat_err_o  out  1  burst illegal; constant for all beats of the burst.

Behaviour:
- Reset (async assert, sync deassert OK): state=IDLE, cmd_ready_o=1, beat_valid_o=0, beat_addr_o=0, beat_idx_o=0, beat_last_o=0, beat_err_o=0. Reset mid-burst aborts the burst; no further beats.
- FSM IDLE -> BURST on cmd_valid_i&&cmd_ready_o. BURST -> IDLE on beat_valid_o&&beat_ready_i&&beat_last_o. cmd_ready_o = (state==IDLE), registered; no back-to-back overlap; one idle cycle between bursts.
- Latency: command accepted at edge N; first beat valid from cycle N+1.
- All command fields are captured at accept and held; inputs are don't-care during BURST.
- beat_valid_o stays high in BURST. addr, idx, last and err are stable while valid&&!ready.
- Advance only on valid&&ready: idx+1, next address per burst type. last = (idx==len); len=0 gives last on beat 0.
- Address rules, with bytes = 1<<size and aligned = addr with low size bits cleared:
  - FIXED: every beat = start address.
  - INCR: beat0 = start (may be unaligned); beat k = aligned(start) + k*bytes. Arithmetic is modulo 2^ADDR_WIDTH.
  - WRAP: container = bytes*(len+1); lower = start & ~(container-1). Next = cur+bytes; if next == lower+container, then next = lower.
- Error (beat_err_o=1), computed at accept:
  - burst==2'b11 (beats generated as FIXED);
  - size > log2(DATA_WIDTH/8) (addresses generated normally);
  - WRAP with len not in {1,3,7,15}, or WRAP start not size-aligned (generated as FIXED);
  - INCR whose aligned(start)+len*bytes lies in a different 4 KB page from start (generated normally).
  - An erroneous burst still produces exactly len+1 beats so that downstream response counting stays consistent.
- Counters: idx is 8 bits and never exceeds len; container is at most 16*128 = 2048 bytes, so internal width is ADDR_WIDTH.

Test Plan:
1. INCR: size=2, len=3, addr=0x1002 -> beats 0x1002, 0x1004, 0x1008, 0x100C; idx 0..3; last only on idx 3; err=0; first valid 1 cycle after accept.
2. WRAP: size=2, len=3, addr=0x1038 -> 0x1038, 0x103C, 0x1030, 0x1034, last on 0x1034; WRAP size=3, len=1, addr=0x2008 -> 0x2008, 0x2000.
3. FIXED: len=2, addr=0x2000 -> three beats of 0x2000, last on the third; then len=0 -> single beat, last=1, and cmd_ready_o returns high the next cycle.
4. Illegal: burst=2'b11 len=1 -> 2 beats, err=1; WRAP len=2 -> 3 beats, err=1; size=4 with DATA_WIDTH=64 -> err=1; INCR size=2 len=3 addr=0x0FF8 -> err=1 (4 KB crossing).
5. Backpressure: during INCR burst 1, beat_ready_i low for 3 cycles at idx 1 -> addr=0x1004, idx=1, last=0 held stable; cmd_valid_i held high meanwhile -> cmd_ready_o stays 0.
6. Reset: assert rst_ni low at idx 2 of a len=7 burst -> outputs take reset values immediately (async); after release the next command starts at idx 0.

Source files
------------

// File: rtl/axi_burst_addr_gen_if.sv
// Command and beat-descriptor channels of the per-beat AXI address generator.
// The master side issues burst commands and consumes beats; the slave side is the generator.
interface axi_burst_addr_gen_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [7:0]            cmd_len_i;
   logic [2:0]            cmd_size_i;
   logic [1:0]            cmd_burst_i;
   logic                  beat_valid_o;
   logic                  beat_ready_i;
   logic [ADDR_WIDTH-1:0] beat_addr_o;
   logic [7:0]            beat_idx_o;
   logic                  beat_last_o;
   logic                  beat_err_o;

   modport master (
      output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i, beat_ready_i,
      input  cmd_ready_o, beat_valid_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
   );

   modport slave (
      input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i, beat_ready_i,
      output cmd_ready_o, beat_valid_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
   );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Turns one AXI burst command into len+1 beat descriptors (address, index, last, error).
// Legality is decided once at accept; illegal bursts still emit the full beat count.
module axi_burst_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   axi_burst_addr_gen_if.slave bus
);
   localparam logic [2:0]            MAX_SIZE    = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [ADDR_WIDTH-1:0] ONE         = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [1:0]            BURST_FIXED = 2'b00;
   localparam logic [1:0]            BURST_INCR  = 2'b01;
   localparam logic [1:0]            BURST_WRAP  = 2'b10;
   localparam logic [1:0]            BURST_RSVD  = 2'b11;

   typedef enum logic {IDLE, BURST} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] lower_q, lower_d;
   logic [ADDR_WIDTH-1:0] bound_q, bound_d;
   logic [7:0]            idx_q, idx_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            mode_q, mode_d;
   logic                  err_q, err_d;

   // Accept-time decode: effective generation mode, error flag and wrap window.
   logic [ADDR_WIDTH-1:0] acc_mask, acc_aligned, acc_last_addr, acc_container, acc_lower;
   logic                  acc_wrap_ok, acc_err;
   logic [1:0]            acc_mode;

   always_comb begin
      acc_mask      = (ONE << bus.cmd_size_i) - ONE;
      acc_aligned   = bus.cmd_addr_i & ~acc_mask;
      acc_last_addr = acc_aligned + ({{(ADDR_WIDTH-8){1'b0}}, bus.cmd_len_i} << bus.cmd_size_i);
      acc_container = {{(ADDR_WIDTH-9){1'b0}}, ({1'b0, bus.cmd_len_i} + 9'd1)} << bus.cmd_size_i;
      acc_lower     = bus.cmd_addr_i & ~(acc_container - ONE);
      acc_wrap_ok   = ((bus.cmd_len_i == 8'd1) || (bus.cmd_len_i == 8'd3) ||
                       (bus.cmd_len_i == 8'd7) || (bus.cmd_len_i == 8'd15)) &&
                      ((bus.cmd_addr_i & acc_mask) == '0);
      acc_mode      = bus.cmd_burst_i;
      acc_err       = (bus.cmd_size_i > MAX_SIZE);
      case (bus.cmd_burst_i)
         BURST_RSVD: begin
            acc_mode = BURST_FIXED;
            acc_err  = 1'b1;
         end
         BURST_WRAP: begin
            if (!acc_wrap_ok) begin
               acc_mode = BURST_FIXED;
               acc_err  = 1'b1;
            end
         end
         BURST_INCR: begin
            if (acc_last_addr[ADDR_WIDTH-1:12] != bus.cmd_addr_i[ADDR_WIDTH-1:12]) begin
               acc_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Address of the following beat; INCR realigns after the (possibly unaligned) first beat.
   logic [ADDR_WIDTH-1:0] beat_bytes, incr_next, wrap_next, next_addr;

   always_comb begin
      beat_bytes = ONE << size_q;
      incr_next  = (addr_q & ~(beat_bytes - ONE)) + beat_bytes;
      wrap_next  = addr_q + beat_bytes;
      if (wrap_next == bound_q) begin
         wrap_next = lower_q;
      end
      case (mode_q)
         BURST_INCR: next_addr = incr_next;
         BURST_WRAP: next_addr = wrap_next;
         default:    next_addr = addr_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lower_q <= '0;
         bound_q <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         size_q  <= '0;
         mode_q  <= BURST_FIXED;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lower_q <= lower_d;
         bound_q <= bound_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         size_q  <= size_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lower_d = lower_q;
      bound_d = bound_q;
      idx_d   = idx_q;
      len_d   = len_q;
      size_d  = size_q;
      mode_d  = mode_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               state_d = BURST;
               addr_d  = bus.cmd_addr_i;
               lower_d = acc_lower;
               bound_d = acc_lower + acc_container;
               idx_d   = '0;
               len_d   = bus.cmd_len_i;
               size_d  = bus.cmd_size_i;
               mode_d  = acc_mode;
               err_d   = acc_err;
            end
         end
         BURST: begin
            if (bus.beat_ready_i) begin
               if (idx_q == len_q) begin
                  state_d = IDLE;
               end else begin
                  idx_d  = idx_q + 8'd1;
                  addr_d = next_addr;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready_o  = (state_q == IDLE);
      bus.beat_valid_o = (state_q == BURST);
      bus.beat_addr_o  = addr_q;
      bus.beat_idx_o   = idx_q;
      bus.beat_last_o  = (state_q == BURST) && (idx_q == len_q);
      bus.beat_err_o   = err_q;
   end
endmodule
